bzone_input_ctrl: RTL and testbench
===================================

Name: bzone_input_ctrl

Overview:
- Input-conditioning stage directly upstream of the bzonetop core.
- Converts MiSTer PS/2 key events and joystick words into the registered, active-low 8-bit button bus that drives bzonetop JB.
- Latches key state and synchronizes the joystick.
- Shapes the coin input into a fixed-width pulse with hold-off, so the game's coin logic always sees a clean, bounded pulse.

Parameters:
- COIN_PULSE_CYC, 2500000, cycles the coin bit is asserted per accepted coin (25 ms at 100 MHz).
- COIN_HOLDOFF_CYC, 5000000, cycles after a pulse during which new coin requests are ignored.
- SYNC_STAGES, 2, flop stages on the joystick inputs (minimum 1).
- AUTOFIRE_PERIOD_CYC, 10000000, half-period of autofire toggling (used only with AUTOFIRE_EN).

Ports:
- clk  in  1  core clock, same clock as bzonetop (clk_100).
- rst_l  in  1  asynchronous active-low reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scancode.
- joy  in  16  OR of both joysticks, active-high: [0] right, [1] left, [4] fire, [5] thrust, [6] shield, [7] start1, [8] coin, [9] start2.
- key_clr  in  1  synchronous clear of all key latches; also aborts the coin FSM.
- autofire_on  in  1  enables autofire. Ignored unless AUTOFIRE_EN is defined.
- buttons_n  out  8  active-low, bit7..0 = {right, left, start1, start2, fire, coin, thrust, shield}.
- coin_busy  out  1  high while the coin FSM is in PULSE or HOLDOFF.

Behaviour:
- Reset (rst_l=0, asynchronous):
  - buttons_n=8'hFF, coin_busy=0.
  - All key latches 0, sync chains 0, coin FSM in IDLE, counters 0.
  - The prev_tog register clears to 0 and the prime flag clears to 0.
- PS/2 event detection:
  - prev_tog registers ps2_key[10] every cycle.
  - An event is decoded when ps2_key[10] != prev_tog and prime=1.
  - prime sets on the first clock after reset, so no spurious event is decoded out of reset.
- Decode, keyed on {ext, scancode}. The indicated latch is set to ps2_key[9]:
  - right: 0x023 (D), 1x074 (arrow right).
  - left: 0x01C (A), 1x06B (arrow left).
  - fire: 0x03A (M), 0x014 (ctrl).
  - thrust: 0x04B (L), 0x011 (Lalt).
  - shield: 0x042 (K), 0x029 (space).
  - start1: 0x005 (F1), 0x016 (1).
  - start2: 0x006 (F2), 0x01E (2).
  - coin: 0x004 (F3), 0x02E (5), 0x036 (6).
  - Extended arrows also match regardless of the extended bit.
  - Unlisted codes leave all latches unchanged.
- Joystick: passes through SYNC_STAGES flops. Each logical request = key latch OR synchronized joystick bit.
- Coin FSM (coin_req = coin key latch OR joy coin):
  - IDLE: on a rising edge of coin_req, go to PULSE and load the counter with COIN_PULSE_CYC-1.
  - PULSE: coin output asserted; count down; at 0, go to HOLDOFF and load COIN_HOLDOFF_CYC-1.
  - HOLDOFF: coin output deasserted; count down; at 0, go to IDLE.
  - Edges of coin_req in PULSE or HOLDOFF are discarded. A request held across the return to IDLE does not retrigger; a new rising edge is required.
- Latency:
  - PS/2 event to buttons_n change: 2 clk.
  - Joystick to buttons_n: SYNC_STAGES+1 clk.
  - coin rising edge to buttons_n[2]=0: 2 clk. The coin bit stays low for exactly COIN_PULSE_CYC cycles.
- key_clr has priority over a same-cycle PS/2 event. Key latches clear; the FSM goes to IDLE with the counter at 0. A still-held joystick coin needs a new edge before it is accepted again.
- All outputs are registered.

Optional Feature:
- AUTOFIRE_EN defined:
  - With autofire_on=1 and the fire request held, the fire output alternates: asserted for AUTOFIRE_PERIOD_CYC cycles, then deasserted for AUTOFIRE_PERIOD_CYC cycles.
  - The cycle starts asserted on the fire rising edge. The phase counter resets when fire is released.
  - With autofire_on=0, fire is a plain pass-through.
- AUTOFIRE_EN undefined: the autofire logic is absent, autofire_on is unused, and fire is a plain pass-through.

Test Plan (COIN_PULSE_CYC=4, COIN_HOLDOFF_CYC=6, SYNC_STAGES=2, AUTOFIRE_PERIOD_CYC=3):
- Release rst_l while ps2_key=11'h400 → no decode; buttons_n stays 8'hFF.
- Toggle bit10 with {pressed=1, ext=1, 0x74} → buttons_n=8'h7F two cycles later. Toggle again with pressed=0 → 8'hFF.
- Pulse F3 press then release → buttons_n=8'hFB for exactly 4 cycles, coin_busy high for 10 cycles. A second F3 press 3 cycles after release is ignored.
- Hold joy[8]=1 continuously → exactly one 4-cycle coin pulse and no retrigger. Drop then raise joy[8] after coin_busy=0 → second pulse.
- Hold ctrl and assert key_clr mid-coin-pulse → fire and coin bits return to 1 next cycle; coin_busy=0.
- AUTOFIRE_EN with autofire_on=1 and ctrl held 12 cycles → bit3 pattern 0,0,0,1,1,1,0,0,0,1,1,1 after 2-cycle latency.

Source files
------------

// File: rtl/bzone_input_ctrl.sv
// Input conditioning for bzonetop: PS/2 key latches, joystick sync, coin pulse shaper.
// Optional autofire on the fire button is compiled in when AUTOFIRE_EN is defined.
module bzone_input_ctrl #(
  parameter int COIN_PULSE_CYC      = 2500000,
  parameter int COIN_HOLDOFF_CYC    = 5000000,
  parameter int SYNC_STAGES         = 2,
  parameter int AUTOFIRE_PERIOD_CYC = 10000000
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [10:0] ps2_key,
  input  logic [15:0] joy,
  input  logic        key_clr,
  input  logic        autofire_on,
  output logic [7:0]  buttons_n,
  output logic        coin_busy
);

  localparam int CNT_MAX = (COIN_PULSE_CYC > COIN_HOLDOFF_CYC) ? COIN_PULSE_CYC : COIN_HOLDOFF_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    COIN_IDLE    = 2'd0,
    COIN_PULSE   = 2'd1,
    COIN_HOLDOFF = 2'd2
  } coin_state_e;

  // Request vectors use the output bit order {right, left, start1, start2, fire, coin, thrust, shield}.
  logic [7:0] key_q, key_d;
  logic [SYNC_STAGES-1:0][7:0] joy_sync_q;
  logic [7:0] joy_vec, joy_s, req;
  logic       prev_tog_q, prime_q, ps2_event;
  logic       dec_hit;
  logic [2:0] dec_idx;
  coin_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       coin_prev_q, coin_req, coin_rise;
  logic       fire_gate;
  logic [7:0] btn_d;
  logic       busy_d;
  logic       unused_joy;

  assign joy_vec    = {joy[0], joy[1], joy[7], joy[9], joy[4], joy[8], joy[5], joy[6]};
  assign unused_joy = ^{joy[15:10], joy[3:2]};
  assign joy_s      = joy_sync_q[SYNC_STAGES-1];
  assign req        = key_q | joy_s;
  assign coin_req   = req[2];
  assign coin_rise  = coin_req & ~coin_prev_q;
  // prime_q masks the toggle comparison on the first clock out of reset.
  assign ps2_event  = prime_q && (ps2_key[10] != prev_tog_q);

  always_comb begin
    dec_hit = 1'b0;
    dec_idx = 3'd0;
    case ({ps2_key[8], ps2_key[7:0]})
      9'h023, 9'h074, 9'h174: begin dec_hit = 1'b1; dec_idx = 3'd7; end
      9'h01C, 9'h06B, 9'h16B: begin dec_hit = 1'b1; dec_idx = 3'd6; end
      9'h005, 9'h016:         begin dec_hit = 1'b1; dec_idx = 3'd5; end
      9'h006, 9'h01E:         begin dec_hit = 1'b1; dec_idx = 3'd4; end
      9'h03A, 9'h014:         begin dec_hit = 1'b1; dec_idx = 3'd3; end
      9'h004, 9'h02E, 9'h036: begin dec_hit = 1'b1; dec_idx = 3'd2; end
      9'h04B, 9'h011:         begin dec_hit = 1'b1; dec_idx = 3'd1; end
      9'h042, 9'h029:         begin dec_hit = 1'b1; dec_idx = 3'd0; end
      default: ;
    endcase
  end

  always_comb begin
    key_d = key_q;
    if (key_clr) begin
      key_d = '0;
    end else if (ps2_event && dec_hit) begin
      key_d[dec_idx] = ps2_key[9];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (key_clr) begin
      state_d = COIN_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        COIN_IDLE: begin
          if (coin_rise) begin
            state_d = COIN_PULSE;
            cnt_d   = CNT_W'(COIN_PULSE_CYC - 1);
          end
        end
        COIN_PULSE: begin
          if (cnt_q == '0) begin
            state_d = COIN_HOLDOFF;
            cnt_d   = CNT_W'(COIN_HOLDOFF_CYC - 1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        COIN_HOLDOFF: begin
          if (cnt_q == '0) begin
            state_d = COIN_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = COIN_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef AUTOFIRE_EN
  localparam int AF_W = $clog2(AUTOFIRE_PERIOD_CYC + 1);
  logic [AF_W-1:0] af_cnt_q, af_cnt_d;
  logic            af_phase_q, af_phase_d;

  // Phase 0 = fire asserted; the counter restarts whenever fire is released.
  always_comb begin
    af_cnt_d   = '0;
    af_phase_d = 1'b0;
    if (req[3]) begin
      if (af_cnt_q == AF_W'(AUTOFIRE_PERIOD_CYC - 1)) begin
        af_phase_d = ~af_phase_q;
      end else begin
        af_cnt_d   = af_cnt_q + AF_W'(1);
        af_phase_d = af_phase_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      af_cnt_q   <= '0;
      af_phase_q <= 1'b0;
    end else begin
      af_cnt_q   <= af_cnt_d;
      af_phase_q <= af_phase_d;
    end
  end

  assign fire_gate = ~(autofire_on & af_phase_q);
`else
  logic unused_autofire;
  assign unused_autofire = autofire_on;
  assign fire_gate       = 1'b1;
`endif

  // key_clr masks key and coin contributions immediately so the outputs drop on the same edge.
  always_comb begin
    btn_d    = (key_clr ? 8'h00 : key_q) | joy_s;
    btn_d[2] = (state_q == COIN_PULSE) && !key_clr;
    btn_d[3] = btn_d[3] & fire_gate;
    busy_d   = (state_q != COIN_IDLE) && !key_clr;
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      prev_tog_q  <= 1'b0;
      prime_q     <= 1'b0;
      key_q       <= '0;
      joy_sync_q  <= '0;
      state_q     <= COIN_IDLE;
      cnt_q       <= '0;
      coin_prev_q <= 1'b0;
      buttons_n   <= 8'hFF;
      coin_busy   <= 1'b0;
    end else begin
      prev_tog_q    <= ps2_key[10];
      prime_q       <= 1'b1;
      key_q         <= key_d;
      joy_sync_q[0] <= joy_vec;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        joy_sync_q[i] <= joy_sync_q[i-1];
      end
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      coin_prev_q <= coin_req;
      buttons_n   <= ~btn_d;
      coin_busy   <= busy_d;
    end
  end

endmodule

// File: tb/tb_bzone_input_ctrl.sv
// Bench for bzone_input_ctrl: timeline-level reference model checked every cycle plus directed literals.
module tb_bzone_input_ctrl;
  localparam int P  = 4;
  localparam int H  = 6;
  localparam int S  = 2;
  localparam int AP = 3;
  localparam int NONE = -100000;

  logic        clk = 1'b0;
  logic        rst_l = 1'b0;
  logic [10:0] ps2_key = 11'h400;
  logic [15:0] joy = 16'h0000;
  logic        key_clr = 1'b0;
  logic        autofire_on = 1'b0;
  logic [7:0]  buttons_n;
  logic        coin_busy;

  int n_checks = 0;
  int n_pass   = 0;

  bzone_input_ctrl #(
    .COIN_PULSE_CYC(P), .COIN_HOLDOFF_CYC(H), .SYNC_STAGES(S), .AUTOFIRE_PERIOD_CYC(AP)
  ) dut (
    .clk(clk), .rst_l(rst_l), .ps2_key(ps2_key), .joy(joy), .key_clr(key_clr),
    .autofire_on(autofire_on), .buttons_n(buttons_n), .coin_busy(coin_busy)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Output bit index by key code; -1 when the code is not a game key.
  function automatic int key_bit(input logic ext, input logic [7:0] code);
    if (code == 8'h74 || code == 8'h6B) return (code == 8'h74) ? 7 : 6;
    if (ext) return -1;
    case (code)
      8'h23: return 7;
      8'h1C: return 6;
      8'h05, 8'h16: return 5;
      8'h06, 8'h1E: return 4;
      8'h3A, 8'h14: return 3;
      8'h04, 8'h2E, 8'h36: return 2;
      8'h4B, 8'h11: return 1;
      8'h42, 8'h29: return 0;
      default: return -1;
    endcase
  endfunction

  function automatic logic [7:0] joy_bits(input logic [15:0] j);
    return {j[0], j[1], j[7], j[9], j[4], j[8], j[5], j[6]};
  endfunction

  logic [7:0] m_key;
  logic [7:0] m_pipe [S];
  int         m_e, m_cstart, m_fstart;
  logic       m_prev_req, m_prevtog;
  logic [7:0] m_exp_btn;
  logic       m_exp_busy;

  task automatic model_reset();
    m_key = '0;
    for (int i = 0; i < S; i++) m_pipe[i] = '0;
    m_e = 0; m_cstart = NONE; m_fstart = 0;
    m_prev_req = 1'b0; m_prevtog = 1'b0;
    m_exp_btn = 8'hFF; m_exp_busy = 1'b0;
  endtask

  // Predict the outputs after the next edge from the current inputs, then advance one cycle.
  task automatic model_step();
    logic [7:0] js, req, outv;
    int d, idx;
    logic pulse, busy, fire_now;
    js    = m_pipe[S-1];
    req   = m_key | js;
    d     = m_e - m_cstart;
    pulse = (d >= 0) && (d < P);
    busy  = (d >= 0) && (d < P + H);
    outv    = (key_clr ? 8'h00 : m_key) | js;
    outv[2] = pulse && !key_clr;
`ifdef AUTOFIRE_EN
    if (autofire_on && req[3] && (((m_e - m_fstart) / AP) % 2 == 1)) outv[3] = 1'b0;
`endif
    m_exp_btn  = ~outv;
    m_exp_busy = busy && !key_clr;
    if (key_clr) m_cstart = NONE;
    else if (!busy && req[2] && !m_prev_req) m_cstart = m_e + 1;
    m_prev_req = req[2];
    if (key_clr) m_key = '0;
    else if (m_e >= 1 && ps2_key[10] != m_prevtog) begin
      idx = key_bit(ps2_key[8], ps2_key[7:0]);
      if (idx >= 0) m_key[idx] = ps2_key[9];
    end
    m_prevtog = ps2_key[10];
    for (int i = S - 1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
    m_pipe[0] = joy_bits(joy);
    m_e++;
    fire_now = m_key[3] | m_pipe[S-1][3];
    if (fire_now && !req[3]) m_fstart = m_e;
  endtask

  always @(negedge clk) begin
    if (!rst_l) model_reset();
    check8("cyc_buttons", buttons_n, m_exp_btn);
    check1("cyc_busy", coin_busy, m_exp_busy);
    if (rst_l) model_step();
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_ev(input logic pressed, input logic ext, input logic [7:0] code);
    ps2_key = {~ps2_key[10], pressed, ext, code};
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached, got %0t expected completion", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int low, busy, falls;
    logic prev_c;
    logic [11:0] af_exp;

    // Reset and release with toggle bit already high
    tick(3);
    check8("reset_buttons", buttons_n, 8'hFF);
    check1("reset_busy", coin_busy, 1'b0);
    rst_l = 1'b1;
    tick(3);
    check8("no_spurious_event", buttons_n, 8'hFF);

    // Extended arrow right press/release, plain 0x74, unlisted codes
    ps2_ev(1, 1, 8'h74); tick(1);
    check8("arrow_latency1", buttons_n, 8'hFF);
    tick(1);
    check8("arrow_right_press", buttons_n, 8'h7F);
    ps2_ev(0, 1, 8'h74); tick(2);
    check8("arrow_right_release", buttons_n, 8'hFF);
    ps2_ev(1, 0, 8'h74); tick(2);
    check8("arrow_noext", buttons_n, 8'h7F);
    ps2_ev(0, 0, 8'h74); tick(2);
    ps2_ev(1, 0, 8'h15); tick(2);
    check8("unlisted_code", buttons_n, 8'hFF);
    ps2_ev(1, 1, 8'h14); tick(2);
    check8("ext_ctrl_unlisted", buttons_n, 8'hFF);

    // Several keys at once: space, Lalt, 2
    ps2_ev(1, 0, 8'h29); tick(1);
    ps2_ev(1, 0, 8'h11); tick(1);
    ps2_ev(1, 0, 8'h1E); tick(2);
    check8("multi_keys", buttons_n, 8'hEC);
    ps2_ev(0, 0, 8'h29); tick(1);
    ps2_ev(0, 0, 8'h11); tick(1);
    ps2_ev(0, 0, 8'h1E); tick(2);
    check8("multi_release", buttons_n, 8'hFF);

    // F3 tap, second tap 3 cycles later must be ignored
    low = 0; busy = 0;
    for (int k = 0; k < 30; k++) begin
      if (k == 0 || k == 4) ps2_ev(1, 0, 8'h04);
      if (k == 1 || k == 5) ps2_ev(0, 0, 8'h04);
      tick(1);
      if (buttons_n[2] == 1'b0) low++;
      if (coin_busy) busy++;
    end
    check_int("f3_pulse_len", low, P);
    check_int("f3_busy_len", busy, P + H);

    // Joystick pass-through latency
    joy = 16'h0001; tick(2);
    check8("joy_right_early", buttons_n, 8'hFF);
    tick(1);
    check8("joy_right", buttons_n, 8'h7F);
    joy = 16'h0000; tick(3);

    // Held joystick coin: one pulse only; re-raise gives another
    for (int r = 0; r < 2; r++) begin
      low = 0; falls = 0; prev_c = 1'b1;
      joy = 16'h0100;
      for (int k = 0; k < 30; k++) begin
        tick(1);
        if (buttons_n[2] == 1'b0) low++;
        if (prev_c && !buttons_n[2]) falls++;
        prev_c = buttons_n[2];
      end
      check_int("joy_coin_pulse_len", low, P);
      check_int("joy_coin_pulses", falls, 1);
      joy = 16'h0000; tick(3);
    end

    // key_clr aborts a coin pulse and clears held ctrl
    ps2_ev(1, 0, 8'h14); tick(2);
    check8("ctrl_fire", buttons_n, 8'hF7);
    ps2_ev(1, 0, 8'h04); tick(3);
    check8("ctrl_and_coin", buttons_n, 8'hF3);
    check1("coin_busy_mid", coin_busy, 1'b1);
    tick(1);
    key_clr = 1'b1; tick(1);
    check8("key_clr_buttons", buttons_n, 8'hFF);
    check1("key_clr_busy", coin_busy, 1'b0);
    key_clr = 1'b0; tick(1);
    check8("after_clr_buttons", buttons_n, 8'hFF);
    ps2_ev(0, 0, 8'h14); tick(1);
    ps2_ev(0, 0, 8'h04); tick(12);

    // key_clr wins over a same-cycle event
    key_clr = 1'b1; ps2_ev(1, 0, 8'h23); tick(1);
    key_clr = 1'b0; tick(2);
    check8("clr_priority", buttons_n, 8'hFF);
    ps2_ev(0, 0, 8'h23); tick(2);

    // Autofire with ctrl held
`ifdef AUTOFIRE_EN
    af_exp = 12'b000111000111;
`else
    af_exp = 12'b000000000000;
`endif
    autofire_on = 1'b1;
    ps2_ev(1, 0, 8'h14); tick(2);
    for (int i = 0; i < 12; i++) begin
      check1("autofire_bit3", buttons_n[3], af_exp[11-i]);
      tick(1);
    end
    ps2_ev(0, 0, 8'h14); autofire_on = 1'b0; tick(3);
    check8("final_idle", buttons_n, 8'hFF);

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
